// File: rtl/sha256_w_sched_stream.sv
// Streaming SHA-256 message-schedule generator: loads one 512-bit block and emits W[0..NUM_ROUNDS-1].
// Optional macro SHA256_WK_PREADD_EN adds a K-constant ROM and a registered W[t]+K[t] output (wk_out).
module sha256_w_sched_stream #(
    parameter int unsigned NUM_ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] block_in,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         w_last
`ifdef SHA256_WK_PREADD_EN
    ,
    output logic [31:0]  wk_out
`endif
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned WIN_N  = 16;

    typedef enum logic {IDLE, RUN} state_e;

`ifdef SHA256_WK_PREADD_EN
    localparam logic [WORD_W-1:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  t_q, t_d;
    logic [WORD_W-1:0] win_q [WIN_N];
    logic [WORD_W-1:0] win_d [WIN_N];
    logic              w_valid_q, w_valid_d;
    logic              w_last_q, w_last_d;
    logic              advance;
    logic              accept;
    logic [WORD_W-1:0] expand;
`ifdef SHA256_WK_PREADD_EN
    logic [WORD_W-1:0] wk_q, wk_d;
`endif

    // Next-state: load on accept, shift-and-expand on advance, otherwise hold.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        win_d     = win_q;
        w_valid_d = w_valid_q;
`ifdef SHA256_WK_PREADD_EN
        wk_d      = wk_q;
`endif
        advance   = (state_q == RUN) && w_ready;
        blk_ready = (state_q == IDLE) || (advance && w_last_q);
        accept    = blk_valid && blk_ready;
        expand    = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

        if (accept) begin
            for (int i = 0; i < WIN_N; i++) begin
                win_d[i] = block_in[511 - 32*i -: 32];
            end
            t_d       = '0;
            state_d   = RUN;
            w_valid_d = 1'b1;
`ifdef SHA256_WK_PREADD_EN
            wk_d      = block_in[511 -: 32] + K_ROM[0];
`endif
        end else if (advance) begin
            for (int i = 0; i < WIN_N - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WIN_N-1] = expand;
            t_d            = t_q + IDX_W'(1);
`ifdef SHA256_WK_PREADD_EN
            wk_d           = win_q[1] + K_ROM[IDX_W'(t_q + IDX_W'(1))];
`endif
            if (w_last_q) begin
                state_d   = IDLE;
                w_valid_d = 1'b0;
                t_d       = '0;
            end
        end

        w_last_d = (state_d == RUN) && (t_d == IDX_W'(NUM_ROUNDS - 1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            t_q       <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
`ifdef SHA256_WK_PREADD_EN
            wk_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            w_valid_q <= w_valid_d;
            w_last_q  <= w_last_d;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= win_d[i];
            end
`ifdef SHA256_WK_PREADD_EN
            wk_q      <= wk_d;
`endif
        end
    end

    assign w_valid = w_valid_q;
    assign w_out   = win_q[0];
    assign w_idx   = t_q;
    assign w_last  = w_last_q;
`ifdef SHA256_WK_PREADD_EN
    assign wk_out  = wk_q;
`endif

endmodule

// File: tb/tb_sha256_w_sched_stream.sv
// Scoreboard bench for sha256_w_sched_stream: FIPS 180-4 schedule model vs streamed words.
// Define SHA256_WK_PREADD_EN on both files to also check wk_out.
module tb_sha256_w_sched_stream;

    logic         CLK;
    logic         RST;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] block_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
`ifdef SHA256_WK_PREADD_EN
    logic [31:0]  wk_out;
    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

    sha256_w_sched_stream #(.NUM_ROUNDS(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .block_in  (block_in),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .w_idx     (w_idx),
        .w_last    (w_last)
`ifdef SHA256_WK_PREADD_EN
        ,
        .wk_out    (wk_out)
`endif
    );

    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
        logic [31:0] wk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   stall_pct = 0;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference model: full FIPS 180-4 schedule for one block, queued as expected words.
    task automatic push_block(input logic [511:0] b);
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            e.w    = w[t];
            e.idx  = 6'(t);
            e.last = (t == 63);
`ifdef SHA256_WK_PREADD_EN
            e.wk   = w[t] + K_TB[t];
`else
            e.wk   = 32'h0;
`endif
            sb_q.push_back(e);
        end
    endtask

    // Present a block until accepted; optionally keep blk_valid high afterwards.
    task automatic send_block(input logic [511:0] b, input bit hold);
        int n = 0;
        bit got = 1'b0;
        blk_valid = 1'b1;
        block_in  = b;
        while (!got && n < 2000) begin
            @(negedge CLK);
            if (blk_ready) got = 1'b1;
            else n++;
        end
        chk("blk_accept", 32'(got), 32'd1);
        @(posedge CLK);
        if (got) push_block(b);
        #1;
        if (!hold) blk_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        #1;
    endtask

    // Consumer back-pressure.
    initial begin
        w_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            w_ready = ($urandom_range(99) >= stall_pct);
        end
    end

    // Monitor: compares presented word with scoreboard head every cycle, pops on handshake.
    always @(negedge CLK) begin
        if (!RST) begin
            if (sb_q.size() != 0) begin
                mon_e = sb_q[0];
                chk("w_valid", 32'(w_valid), 32'd1);
                chk("w_out", w_out, mon_e.w);
                chk("w_idx", 32'(w_idx), 32'(mon_e.idx));
                chk("w_last", 32'(w_last), 32'(mon_e.last));
`ifdef SHA256_WK_PREADD_EN
                chk("wk_out", wk_out, mon_e.wk);
`endif
                chk("blk_ready_run", 32'(blk_ready), 32'(mon_e.last && w_ready));
                if (w_ready) void'(sb_q.pop_front());
            end else begin
                chk("w_valid_idle", 32'(w_valid), 32'd0);
                chk("blk_ready_idle", 32'(blk_ready), 32'd1);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] rb;
        int n;
        RST       = 1'b1;
        blk_valid = 1'b0;
        block_in  = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_w_idx", 32'(w_idx), 32'd0);
        chk("rst_w_last", 32'(w_last), 32'd0);
`ifdef SHA256_WK_PREADD_EN
        chk("rst_wk_out", wk_out, 32'd0);
`endif
        @(posedge CLK);
        #1;

        // abc block, no stalls; then with ~30% stalls
        stall_pct = 0;
        send_block(ABC_BLK, 1'b0);
        drain();
        stall_pct = 30;
        send_block(ABC_BLK, 1'b0);
        drain();

        // Back-to-back blocks with blk_valid held across the boundary
        stall_pct = 0;
        send_block(ABC_BLK, 1'b1);
        rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_block(rb, 1'b0);
        drain();

        // Reset while idx 20 is presented, then restart
        send_block(ABC_BLK, 1'b0);
        n = 0;
        while (!(sb_q.size() != 0 && sb_q[0].idx == 6'd20) && n < 200) begin
            @(posedge CLK);
            #2;
            n++;
        end
        chk("reach_idx20", 32'(n < 200), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        sb_q.delete();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_w_valid", 32'(w_valid), 32'd0);
        @(posedge CLK);
        #1;
        send_block(ABC_BLK, 1'b0);
        drain();

        // Random blocks with light stalls and random gaps
        stall_pct = 3;
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < 16; i++) rb[511 - 32*i -: 32] = $urandom;
            send_block(rb, ($urandom_range(1) == 1));
        end
        blk_valid = 1'b0;
        drain();

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
